// File: rtl/ic_bvugt_bvashr1_checker.sv
// Bit-serial witness checker for the bvugt/bvashr invertibility constraint (s >>a x) >u t.
// Accepts an (s, t, x) triple, arithmetically shifts s right one bit per cycle, then
// compares the result against t (unsigned) and holds the verdict until consumed.
// Optional feature macro: IC_BVUGT_BVASHR1_IC_EN adds the invertibility condition output
// out_ic and the sticky ic_err flag; without it out_ic is tied low.
module ic_bvugt_bvashr1_checker #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_s,
  input  logic [W-1:0]     in_t,
  input  logic [W-1:0]     in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic [W-1:0]     out_res,
  output logic             out_ic,
  output logic [CNT_W-1:0] pass_cnt,
`ifdef IC_BVUGT_BVASHR1_IC_EN
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ic_err
`else
  output logic [CNT_W-1:0] fail_cnt
`endif
);

  // Remaining-shift counter must hold values 0..W.
  localparam int unsigned RW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q;
  logic [W-1:0]   t_q;
  logic [RW-1:0]  rem_q;
  logic [RW-1:0]  rem_init;
  logic           accept;
  logic           deliver;

  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign out_valid = (state_q == StDone);
  // Gated with rst_n so the producer never sees ready while the block is held in reset.
  assign in_ready  = (state_q == StIdle) && rst_n;

  // Clamp the shift amount: shifting by W or more is full sign fill, same as W-1.
  always_comb begin
    rem_init = RW'(W);
    if (32'(in_x) < W) rem_init = RW'(in_x);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (rem_q == '0) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand capture, serial arithmetic shift and verdict registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      t_q     <= '0;
      rem_q   <= '0;
      out_res <= '0;
      out_sat <= 1'b0;
    end else begin
      if (state_q == StIdle && accept) begin
        shreg_q <= in_s;
        t_q     <= in_t;
        rem_q   <= rem_init;
      end else if (state_q == StShift) begin
        if (rem_q != '0) begin
          shreg_q <= {shreg_q[W-1], shreg_q[W-1:1]};
          rem_q   <= rem_q - 1'b1;
        end else begin
          out_res <= shreg_q;
          out_sat <= (shreg_q > t_q);
        end
      end
    end
  end

  // Saturating verdict counters, stepped once per delivered verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (deliver) begin
      if (out_sat) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

`ifdef IC_BVUGT_BVASHR1_IC_EN
  logic ic_cap_q;
  logic ic_in;

  // Some x exists iff: negative s can reach any value but all-ones via sign fill;
  // non-negative s only decreases under shifting, so s itself must already exceed t.
  always_comb begin
    ic_in = in_s[W-1] ? (in_t != '1) : (in_s > in_t);
  end

  // IC captured with the operands, published together with the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_cap_q <= 1'b0;
      out_ic   <= 1'b0;
      ic_err   <= 1'b0;
    end else begin
      if (state_q == StIdle && accept) ic_cap_q <= ic_in;
      if (state_q == StShift && rem_q == '0) out_ic <= ic_cap_q;
      // A satisfied check where no witness should exist means the checker path is broken.
      if (deliver && out_sat && !out_ic) ic_err <= 1'b1;
    end
  end
`else
  assign out_ic = 1'b0;
`endif

endmodule

// File: tb/tb_ic_bvugt_bvashr1_checker.sv
// Directed self-checking bench for ic_bvugt_bvashr1_checker (W=4, CNT_W=2).
module tb_ic_bvugt_bvashr1_checker;

  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_s, in_t, in_x;
  logic             out_valid;
  logic             out_ready;
  logic             out_sat;
  logic [W-1:0]     out_res;
  logic             out_ic;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
`ifdef IC_BVUGT_BVASHR1_IC_EN
  logic             ic_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ic_bvugt_bvashr1_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_t      (in_t),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_res   (out_res),
    .out_ic    (out_ic),
    .pass_cnt  (pass_cnt),
`ifdef IC_BVUGT_BVASHR1_IC_EN
    .fail_cnt  (fail_cnt),
    .ic_err    (ic_err)
`else
    .fail_cnt  (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one triple with out_ready high, check latency, verdict and delivery.
  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] t, input logic [W-1:0] x,
                       input logic [W-1:0] e_res, input logic e_sat, input logic e_ic,
                       input int e_lat, input int e_pass, input int e_fail);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_s = s; in_t = t; in_x = x;
    check("rdy_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, e_lat);
    check("res", 32'(out_res), 32'(e_res));
    check("sat", 32'(out_sat), 32'(e_sat));
    check("rdy_busy", 32'(in_ready), 32'd0);
`ifdef IC_BVUGT_BVASHR1_IC_EN
    check("ic", 32'(out_ic), 32'(e_ic));
`else
    check("ic_off", 32'(out_ic), 32'd0);
`endif
    @(posedge clk); #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("pass_cnt", 32'(pass_cnt), 32'(e_pass));
    check("fail_cnt", 32'(fail_cnt), 32'(e_fail));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_s = '0; in_t = '0; in_x = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'(out_res), 32'd0);
    check("rst_sat", 32'(out_sat), 32'd0);
    check("rst_pass", 32'(pass_cnt), 32'd0);
    check("rst_fail", 32'(fail_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_rdy", 32'(in_ready), 32'd1);

    // Basic shift, negative saturating shift, zero shift.
    do_op(4'b0110, 4'b0010, 4'd1, 4'b0011, 1'b1, 1'b1, 2, 1, 0);
    do_op(4'b1000, 4'b1101, 4'd2, 4'b1110, 1'b1, 1'b1, 3, 2, 0);
    do_op(4'b1000, 4'b1111, 4'd7, 4'b1111, 1'b0, 1'b0, 5, 2, 1);
    do_op(4'b0101, 4'b0101, 4'd0, 4'b0101, 1'b0, 1'b0, 1, 2, 2);

    // Backpressure with in_valid held high; second triple queued behind it.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_s = 4'b0111; in_t = 4'b0001; in_x = 4'd1;
    @(posedge clk); #1;
    in_s = 4'b0100; in_t = 4'b0000; in_x = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_res", 32'(out_res), 32'b0011);
      check("bp_hold_sat", 32'(out_sat), 32'd1);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
      check("bp_hold_pass", 32'(pass_cnt), 32'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_deliver_pass", 32'(pass_cnt), 32'd3);
    check("bp_deliver_fail", 32'(fail_cnt), 32'd2);
    check("bp_deliver_valid", 32'(out_valid), 32'd0);
    check("bp_deliver_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp2_valid", 32'(out_valid), 32'd1);
    check("bp2_res", 32'(out_res), 32'b0100);
    check("bp2_sat", 32'(out_sat), 32'd1);
    @(posedge clk); #1;
    check("sat_pass4", 32'(pass_cnt), 32'd3);

    do_op(4'b0110, 4'b0010, 4'd1, 4'b0011, 1'b1, 1'b1, 2, 3, 2);

    // Reset while SHIFT has two shifts left.
    @(negedge clk);
    in_valid = 1'b1;
    in_s = 4'b0110; in_t = 4'b0000; in_x = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    check("mid_rst_res", 32'(out_res), 32'd0);
    check("mid_rst_sat", 32'(out_sat), 32'd0);
    check("mid_rst_pass", 32'(pass_cnt), 32'd0);
    check("mid_rst_fail", 32'(fail_cnt), 32'd0);
    check("mid_rst_ic", 32'(out_ic), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b0011, 4'b0001, 4'd1, 4'b0001, 1'b0, 1'b1, 2, 0, 1);

`ifdef IC_BVUGT_BVASHR1_IC_EN
    check("ic_err", 32'(ic_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ic_bvugt_bvashr1_checker.md
# ic_bvugt_bvashr1_checker

Sequential witness checker for the `bvugt`/`bvashr` invertibility constraint `(s >>a x) >u t`. Skolem-function blocks generate a shift amount `x` for given `s`, `t`; this block consumes `s`, `t` and the produced `x`, evaluates the constraint bit-serially, and returns a pass/fail verdict. It sits downstream of the Skolem generator as the independent check on its output.

## Interface
- `W`, default 4: operand width in bits. Legal range 2..16.
- `CNT_W`, default 16: width of the pass/fail counters.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand triple valid
- `in_ready`  out  1  checker can accept a triple
- `in_s`  in  W  value being shifted
- `in_t`  in  W  comparison threshold
- `in_x`  in  W  shift amount, unsigned witness
- `out_valid`  out  1  verdict valid
- `out_ready`  in  1  consumer accepts verdict
- `out_sat`  out  1  1 when `(s >>a x) >u t`
- `out_res`  out  W  computed `s >>a x`
- `out_ic`  out  1  invertibility condition for (`s`, `t`); 0 when the macro is absent
- `pass_cnt`  out  CNT_W  saturating count of delivered verdicts with `out_sat=1`
- `fail_cnt`  out  CNT_W  saturating count of delivered verdicts with `out_sat=0`

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready`, capture `shreg<=in_s`, `t_q<=in_t`, `rem<=min(in_x, W)`, then go to SHIFT.
- SHIFT:
  - If `rem!=0`: `shreg <= {shreg[W-1], shreg[W-1:1]}` and `rem<=rem-1`.
  - If `rem==0`: register `out_res<=shreg` and `out_sat<=(shreg >u t_q)`, then go to DONE.
  - A shift amount of `W` or more yields full sign fill, which is identical to a shift of `W-1`.
- DONE:
  - `out_valid=1`; `out_res`, `out_sat` and `out_ic` are held stable.
  - On `out_ready`, increment `pass_cnt` or `fail_cnt` and go to IDLE.
- `in_ready` is 1 only in IDLE. No new triple is accepted in SHIFT or DONE, including the cycle in which DONE is left.
- Comparison is unsigned over W bits. `t_q` is not modified.
- Counters stick at `2^CNT_W-1`.
- Reset values: `in_ready=0` while `rst_n=0` and 1 after release. `out_valid=0`, `out_sat=0`, `out_res=0`, `out_ic=0`, `pass_cnt=0`, `fail_cnt=0`.
- Reset asserted in any state aborts the operation immediately. The partial result is discarded and counters are cleared.

## Timing
- Let the accepting edge be edge 0 and `n=min(x,W)`.
- `out_valid` rises after edge `n+1`. Latency therefore ranges from 1 cycle (`x=0`) to `W+1` cycles.
- Delivery happens on the edge where `out_valid & out_ready`. The counter update is visible after that edge, and `in_ready` rises after the same edge.
- Minimum initiation interval is `n+3` cycles with `out_ready` held high.
- With no backpressure, `out_valid` is high for exactly one cycle.

## Configuration
- Macro `IC_BVUGT_BVASHR1_IC_EN`.
- Defined:
  - Computed alongside the capture step: `ic = s[W-1] ? (t != all-ones) : (s >u t)`. This is the necessary and sufficient condition for some `x` to exist.
  - `out_ic` is registered with the verdict.
  - An extra sticky output `ic_err` (out, 1 bit, reset 0) sets when a verdict is delivered with `out_sat=1` and `out_ic=0`.
  - `ic_err` clears only on reset.
- Undefined: `out_ic` is tied to 0, `ic_err` does not exist, and no IC logic is synthesized.

## Test plan
- **Basic shift, W=4.**
  - Stimulus: `s=0110`, `t=0010`, `x=1`, `out_ready=1`.
  - Required: `out_res=0011`, `out_sat=1`, `out_valid` after edge 2, `pass_cnt=1`, `out_ic=1` (with macro).
- **Negative s with saturating shift.**
  - `s=1000`, `t=1101`, `x=2`: `out_res=1110`, `out_sat=1`.
  - Then `x=7`, `t=1111`: `n=4`, `out_res=1111`, `out_sat=0`, `out_valid` after edge 5, `fail_cnt=1`, `out_ic=0`.
- **Zero shift, non-invertible.**
  - Stimulus: `s=0101`, `t=0101`, `x=0`.
  - Required: `out_valid` after edge 1, `out_sat=0`, `out_ic=0`, `ic_err` stays 0.
- **Backpressure.**
  - Stimulus: `out_ready=0` for 5 cycles in DONE while `in_valid` is held high.
  - Required: outputs stable, `in_ready=0`, no counter change. On the `out_ready=1` edge exactly one counter increments and the next triple is accepted one cycle later.
- **Reset mid-operation.**
  - Stimulus: drop `rst_n` while in SHIFT with `rem=2`.
  - Required: all outputs go to their reset values immediately. After release the next triple is processed normally with counters starting from 0.
- **Counter saturation.**
  - Stimulus: `CNT_W=2`, 5 passing triples.
  - Required: `pass_cnt` reads 3 after the third and stays 3.
